// File: rtl/uart_tx_arbiter_if.sv
// Byte handshake bundle: requesters and the uarttx transmitter on one side,
// the round-robin arbiter on the other.
interface uart_tx_arbiter_if #(
   parameter int NREQ = 4
) ();
   logic [NREQ-1:0]   req;
   logic [8*NREQ-1:0] req_data;
   logic [NREQ-1:0]   ack;
   logic              uart_newd;
   logic [7:0]        uart_dintx;
   logic              uart_tx;
   logic              uart_donetx;

   modport master (
      output req, req_data, uart_tx, uart_donetx,
      input  ack, uart_newd, uart_dintx
   );

   modport slave (
      input  req, req_data, uart_tx, uart_donetx,
      output ack, uart_newd, uart_dintx
   );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uarttx transmitter between NREQ byte
// requesters; tracks each frame via the start bit and the donetx rising edge.
module uart_tx_arbiter #(
   parameter int NREQ    = 4,
   parameter int TIMEOUT = 4096
) (
   input  logic             clk,
   input  logic             rst,
   uart_tx_arbiter_if.slave bus,
   output logic             busy,
   output logic [NREQ-1:0]  cur_grant,
   output logic             timeout_err
);
   localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NREQ - 1);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT_DONE,
      RELEASE
   } state_t;

   state_t            state, state_n;
   logic [PTR_W-1:0]  ptr, ptr_n;
   logic [PTR_W-1:0]  grant_idx, grant_idx_n;
   logic [PTR_W-1:0]  sel_idx, cand, next_ptr;
   logic              sel_found;
   logic [TMR_W-1:0]  timer, timer_n;
   logic              donetx_q, donetx_rise;
   logic [NREQ-1:0]   ack_r, ack_n, grant_n;
   logic              newd_r, newd_n;
   logic [7:0]        dintx_r, dintx_n;
   logic              terr_n;
   logic [7:0]        req_bytes [NREQ];

   for (genvar g = 0; g < NREQ; g++) begin : g_bytes
      assign req_bytes[g] = bus.req_data[8*g +: 8];
   end

   // First requesting index found scanning upward from the pointer, with wrap.
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      cand      = '0;
      for (int i = 0; i < NREQ; i++) begin
         cand = PTR_W'((int'(ptr) + i) % NREQ);
         if (!sel_found && bus.req[cand]) begin
            sel_found = 1'b1;
            sel_idx   = cand;
         end
      end
   end

   assign next_ptr    = (grant_idx == PTR_LAST) ? '0 : grant_idx + PTR_W'(1);
   assign donetx_rise = bus.uart_donetx & ~donetx_q;

   always_comb begin
      state_n     = state;
      ptr_n       = ptr;
      grant_idx_n = grant_idx;
      timer_n     = timer;
      ack_n       = '0;
      newd_n      = newd_r;
      dintx_n     = dintx_r;
      grant_n     = cur_grant;
      terr_n      = 1'b0;
      case (state)
         IDLE: begin
            if (sel_found) begin
               grant_idx_n = sel_idx;
               grant_n     = NREQ'(1) << sel_idx;
               dintx_n     = req_bytes[sel_idx];
               timer_n     = '0;
               newd_n      = 1'b1;
               state_n     = ISSUE;
            end
         end
         ISSUE, WAIT_DONE: begin
            // Abort takes priority so a stuck transmitter never holds the bus past the limit.
            if (timer == TMR_LAST) begin
               terr_n  = 1'b1;
               newd_n  = 1'b0;
               ptr_n   = next_ptr;
               grant_n = '0;
               timer_n = '0;
               state_n = IDLE;
            end else if (state == ISSUE && !bus.uart_tx) begin
               newd_n  = 1'b0;
               timer_n = '0;
               state_n = WAIT_DONE;
            end else if (state == WAIT_DONE && donetx_rise) begin
               ack_n   = cur_grant;
               state_n = RELEASE;
            end else begin
               timer_n = timer + TMR_W'(1);
            end
         end
         RELEASE: begin
            ptr_n   = next_ptr;
            grant_n = '0;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         ptr         <= '0;
         grant_idx   <= '0;
         timer       <= '0;
         donetx_q    <= 1'b0;
         ack_r       <= '0;
         newd_r      <= 1'b0;
         dintx_r     <= 8'h00;
         cur_grant   <= '0;
         timeout_err <= 1'b0;
      end else begin
         state       <= state_n;
         ptr         <= ptr_n;
         grant_idx   <= grant_idx_n;
         timer       <= timer_n;
         donetx_q    <= bus.uart_donetx;
         ack_r       <= ack_n;
         newd_r      <= newd_n;
         dintx_r     <= dintx_n;
         cur_grant   <= grant_n;
         timeout_err <= terr_n;
      end
   end

   assign bus.ack        = ack_r;
   assign bus.uart_newd  = newd_r;
   assign bus.uart_dintx = dintx_r;
   assign busy           = (state != IDLE);
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with a behavioural uarttx model and a
// serial decoder on the tx line.
module tb_uart_tx_arbiter;
   localparam int NREQ = 4;
   localparam int TMO  = 64;
   localparam int BIT  = 4;

   typedef struct {
      bit         isTimeout;
      int         idx;
      logic [7:0] data;
   } exp_t;

   logic            clk;
   logic            rst;
   logic            busy;
   logic [NREQ-1:0] cur_grant;
   logic            timeout_err;
   logic            txDead;
   logic            txActive;
   logic            midDrop;
   logic            midRe;

   int vectors;
   int miscompares;

   exp_t       expQ [$];
   logic [7:0] rxQ [$];
   logic [7:0] reqQ [NREQ][$];

   uart_tx_arbiter_if #(.NREQ(NREQ)) bus ();

   uart_tx_arbiter #(
      .NREQ    (NREQ),
      .TIMEOUT (TMO)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus),
      .busy        (busy),
      .cur_grant   (cur_grant),
      .timeout_err (timeout_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h", name, actual, expected);
      end
   endtask

   task automatic failBound(input string name);
      vectors++;
      miscompares++;
      $display("[TB] FAIL %s: wait bound expired", name);
   endtask

   task automatic applyStimulus(input int idx, input logic [7:0] d);
      reqQ[idx].push_back(d);
      if (!bus.req[idx]) begin
         bus.req_data[8*idx +: 8] = d;
         bus.req[idx]             = 1'b1;
      end
   endtask

   task automatic pushExpected(input bit isTimeout, input int idx, input logic [7:0] d);
      exp_t e;
      e.isTimeout = isTimeout;
      e.idx       = idx;
      e.data      = d;
      expQ.push_back(e);
   endtask

   task automatic waitTxLow(input int budget);
      int n = 0;
      while (bus.uart_tx !== 1'b0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (n >= budget) failBound("tx_start_bit");
   endtask

   task automatic waitTxIdle(input int budget);
      int n = 0;
      while (txActive && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (n >= budget) failBound("tx_frame_end");
   endtask

   // Requesters: drop req after the ack of their last queued byte, else present the next one.
   task automatic serveRequesters(input int budget);
      int cyc = 0;
      while ((bus.req != '0 || busy) && cyc < budget) begin
         @(negedge clk);
         cyc++;
         for (int i = 0; i < NREQ; i++) begin
            if (bus.ack[i]) begin
               if (reqQ[i].size() > 0) reqQ[i].delete(0);
               if (reqQ[i].size() > 0) bus.req_data[8*i +: 8] = reqQ[i][0];
               else                    bus.req[i] = 1'b0;
            end
         end
         if (midDrop && busy && bus.uart_tx == 1'b0) begin
            bus.req[0] = 1'b0;
            midDrop    = 1'b0;
            midRe      = 1'b1;
         end else if (midRe) begin
            bus.req_data[7:0] = 8'h5A;
            bus.req[0]        = 1'b1;
            midRe             = 1'b0;
         end
      end
      if (cyc >= budget) failBound("serve_requesters");
   endtask

   // uarttx model: picks up newd, sends start, 8 data bits LSB first, stop, then pulses donetx.
   initial begin
      logic [7:0] b;
      bus.uart_tx     = 1'b1;
      bus.uart_donetx = 1'b0;
      txActive        = 1'b0;
      forever begin
         @(negedge clk);
         if (bus.uart_newd && !txDead) begin
            b           = bus.uart_dintx;
            txActive    = 1'b1;
            bus.uart_tx = 1'b0;
            repeat (BIT) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
               bus.uart_tx = b[i];
               repeat (BIT) @(negedge clk);
            end
            bus.uart_tx = 1'b1;
            repeat (BIT) @(negedge clk);
            bus.uart_donetx = 1'b1;
            repeat (2) @(negedge clk);
            bus.uart_donetx = 1'b0;
            txActive        = 1'b0;
         end
      end
   end

   // Serial decoder: samples each bit mid-period on the posedge.
   initial begin
      logic [7:0] sh;
      forever begin
         @(posedge clk);
         if (bus.uart_tx === 1'b0) begin
            repeat (BIT + BIT/2) @(posedge clk);
            for (int i = 0; i < 8; i++) begin
               sh[i] = bus.uart_tx;
               if (i < 7) repeat (BIT) @(posedge clk);
            end
            repeat (BIT) @(posedge clk);
            rxQ.push_back(sh);
         end
      end
   end

   // Monitor: every ack or timeout pulse retires the oldest expected transaction.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst && (bus.ack != '0 || timeout_err)) begin
            if (expQ.size() == 0) begin
               failBound("unexpected_ack_or_timeout");
            end else begin
               e = expQ.pop_front();
               if (e.isTimeout) begin
                  checkOutput("timeout_pulse", {27'd0, timeout_err, bus.ack}, 32'h10);
               end else begin
                  checkOutput("ack_onehot", {28'd0, bus.ack}, 32'd1 << e.idx);
                  if (rxQ.size() == 0) failBound("tx_frame_missing");
                  else                 checkOutput("tx_byte", {24'd0, rxQ.pop_front()}, {24'd0, e.data});
               end
            end
         end
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not complete");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      logic early;
      vectors      = 0;
      miscompares  = 0;
      rst          = 1'b1;
      bus.req      = '0;
      bus.req_data = '0;
      txDead       = 1'b0;
      midDrop      = 1'b0;
      midRe        = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("rst_ack", {28'd0, bus.ack}, 32'd0);
      checkOutput("rst_newd", {31'd0, bus.uart_newd}, 32'd0);
      checkOutput("rst_dintx", {24'd0, bus.uart_dintx}, 32'd0);
      checkOutput("rst_busy", {31'd0, busy}, 32'd0);
      checkOutput("rst_grant", {28'd0, cur_grant}, 32'd0);
      checkOutput("rst_timeout", {31'd0, timeout_err}, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      $display("[TB] all four requesting, req held");
      for (int k = 0; k < 2; k++) begin
         applyStimulus(0, 8'h11);
         applyStimulus(1, 8'h22);
         applyStimulus(2, 8'h33);
         applyStimulus(3, 8'h44);
         pushExpected(0, 0, 8'h11);
         pushExpected(0, 1, 8'h22);
         pushExpected(0, 2, 8'h33);
         pushExpected(0, 3, 8'h44);
      end
      serveRequesters(2000);

      $display("[TB] single request from requester 1");
      applyStimulus(1, 8'hA5);
      pushExpected(0, 1, 8'hA5);
      @(negedge clk);
      checkOutput("t1_grant", {28'd0, cur_grant}, 32'h2);
      checkOutput("t1_busy", {31'd0, busy}, 32'd1);
      checkOutput("t1_newd_high", {31'd0, bus.uart_newd}, 32'd1);
      checkOutput("t1_dintx", {24'd0, bus.uart_dintx}, 32'hA5);
      waitTxLow(50);
      repeat (2) @(negedge clk);
      checkOutput("t1_newd_low", {31'd0, bus.uart_newd}, 32'd0);
      serveRequesters(500);
      checkOutput("t1_busy_after", {31'd0, busy}, 32'd0);

      $display("[TB] pointer 2 with req 1001");
      applyStimulus(0, 8'h90);
      applyStimulus(3, 8'h93);
      pushExpected(0, 3, 8'h93);
      pushExpected(0, 0, 8'h90);
      @(negedge clk);
      checkOutput("t3_first_grant", {28'd0, cur_grant}, 32'h8);
      serveRequesters(500);
      applyStimulus(0, 8'h60);
      applyStimulus(1, 8'h61);
      pushExpected(0, 1, 8'h61);
      pushExpected(0, 0, 8'h60);
      @(negedge clk);
      checkOutput("t3_ptr_is_1", {28'd0, cur_grant}, 32'h2);
      serveRequesters(500);

      $display("[TB] tx stuck high, timeout");
      txDead = 1'b1;
      early  = 1'b0;
      applyStimulus(2, 8'hB2);
      applyStimulus(3, 8'hC3);
      pushExpected(1, 2, 8'h00);
      pushExpected(0, 3, 8'hC3);
      pushExpected(0, 2, 8'hB2);
      for (int k = 1; k <= TMO + 1; k++) begin
         @(negedge clk);
         if (k == 1) checkOutput("t4_grant", {28'd0, cur_grant}, 32'h4);
         if (k <= TMO) early = early | timeout_err;
      end
      checkOutput("t4_no_early_timeout", {31'd0, early}, 32'd0);
      checkOutput("t4_timeout_err", {31'd0, timeout_err}, 32'd1);
      checkOutput("t4_newd", {31'd0, bus.uart_newd}, 32'd0);
      checkOutput("t4_busy", {31'd0, busy}, 32'd0);
      checkOutput("t4_ack", {28'd0, bus.ack}, 32'd0);
      txDead = 1'b0;
      serveRequesters(1000);

      $display("[TB] reset during WAIT_DONE");
      applyStimulus(0, 8'h77);
      @(negedge clk);
      waitTxLow(50);
      repeat (6) @(negedge clk);
      rst     = 1'b1;
      bus.req = '0;
      reqQ[0].delete();
      @(negedge clk);
      checkOutput("t5_ack", {28'd0, bus.ack}, 32'd0);
      checkOutput("t5_newd", {31'd0, bus.uart_newd}, 32'd0);
      checkOutput("t5_dintx", {24'd0, bus.uart_dintx}, 32'd0);
      checkOutput("t5_busy", {31'd0, busy}, 32'd0);
      checkOutput("t5_grant", {28'd0, cur_grant}, 32'd0);
      checkOutput("t5_timeout", {31'd0, timeout_err}, 32'd0);
      rst = 1'b0;
      waitTxIdle(200);
      repeat (4) @(negedge clk);
      rxQ.delete();
      applyStimulus(0, 8'hA0);
      applyStimulus(1, 8'hA1);
      applyStimulus(2, 8'hA2);
      applyStimulus(3, 8'hA3);
      pushExpected(0, 0, 8'hA0);
      pushExpected(0, 1, 8'hA1);
      pushExpected(0, 2, 8'hA2);
      pushExpected(0, 3, 8'hA3);
      @(negedge clk);
      checkOutput("t5_ptr_reset", {28'd0, cur_grant}, 32'h1);
      serveRequesters(1000);

      $display("[TB] requester 0 drops and reasserts mid-frame");
      midDrop = 1'b1;
      applyStimulus(0, 8'hC3);
      applyStimulus(0, 8'h5A);
      pushExpected(0, 0, 8'hC3);
      pushExpected(0, 0, 8'h5A);
      serveRequesters(1000);

      repeat (10) @(negedge clk);
      checkOutput("exp_queue_drained", expQ.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
